// File: rtl/rr_arb_mux_pkg.sv
// rr_mux_pkg: shared helpers for the round-robin arbitrated mux.
//  - clog2 / sel_width: width of a channel index (at least 1 bit).
//  - onehot_to_idx: converts a one-hot vector (up to 32 bits) to its index.
// Optional feature macro used by the users of this package: RR_ARB_MUX_LOCK_EN.
package rr_mux_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Index width; a single-channel mux still carries a 1-bit out_ch.
    function automatic int sel_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // OR of the indices of all set bits; exact for a one-hot input.
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                r = r | i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: bundle of the per-channel input handshake and the single
// output handshake of rr_arb_mux.
//  in_valid/in_data/in_ready : N producer channels, channel i data at in_data[i*W +: W]
//  out_valid/out_data/out_ch/out_ready : registered output beat and its source channel
//  in_last : end-of-packet marker, present only with RR_ARB_MUX_LOCK_EN
// Modports: master = producers + consumer side, slave = the mux.
interface rr_arb_mux_if
    import rr_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int SELW = sel_width(N);

    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_ready;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [N-1:0]    in_last;
`endif

    modport master (
        output in_valid, in_data, out_ready,
`ifdef RR_ARB_MUX_LOCK_EN
        output in_last,
`endif
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef RR_ARB_MUX_LOCK_EN
        input  in_last,
`endif
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_arb_mux_prio_pick.sv
// rr_prio_pick: combinational rotating-priority picker.
//  req   : request vector, bit i = channel i
//  ptr   : highest-priority channel; priority runs ptr, ptr+1, ..., N-1, 0, ..., ptr-1
//  grant : one-hot grant (zero when no request)
//  idx   : index of the granted channel (0 when no request)
//  any   : at least one request present
module rr_prio_pick
    import rr_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [N-1:0] mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] pick_src;

    // mask selects channels at or above ptr: these win over the wrapped ones.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign mask[gi] = (SELW'(gi) >= ptr);
    end

    assign hi_req   = req & mask;
    assign pick_src = (|hi_req) ? hi_req : req;
    // Isolate the lowest set bit of the chosen half.
    assign grant    = pick_src & (~pick_src + N'(1));
    assign idx      = SELW'(onehot_to_idx(32'(grant)));
    assign any      = |req;

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel, W-bit registered selector with round-robin arbitration.
//  clk   : rising-edge clock
//  rst_b : asynchronous active-low reset
//  bus   : rr_arb_mux_if.slave (per-channel valid/data/ready in, registered
//          valid/data/channel out with out_ready back-pressure)
// Optional: RR_ARB_MUX_LOCK_EN adds in_last and packet locking; a channel that
// transfers a non-last beat keeps the grant until its last beat.
module rr_arb_mux
    import rr_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    rr_arb_mux_if.slave bus
);

    localparam int SELW = sel_width(N);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
`ifdef RR_ARB_MUX_LOCK_EN
    logic            lock_q, lock_d;
    logic [SELW-1:0] owner_q, owner_d;
    logic            last_sel;
`endif

    logic            load;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [SELW-1:0] idx;
    logic            any;
    logic [W-1:0]    sel_data;
    logic [SELW-1:0] ptr_after;
    logic [W-1:0]    chan_data [N];

    // The output register can take a new beat when empty or being drained.
    assign load = !out_valid_q || bus.out_ready;

`ifdef RR_ARB_MUX_LOCK_EN
    // While locked only the owner may be granted, even if it is idle.
    assign req      = lock_q ? (bus.in_valid & (N'(1) << owner_q)) : bus.in_valid;
    assign last_sel = |(grant & bus.in_last);
`else
    assign req = bus.in_valid;
`endif

    rr_prio_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign chan_data[gi] = bus.in_data[gi*W +: W];
    end

    // AND-OR mux keyed by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | chan_data[i];
            end
        end
    end

    assign ptr_after = (idx == SELW'(N - 1)) ? '0 : idx + SELW'(1);

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
`ifdef RR_ARB_MUX_LOCK_EN
        lock_d      = lock_q;
        owner_d     = owner_q;
`endif
        if (load) begin
            if (any) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_ch_d    = idx;
`ifdef RR_ARB_MUX_LOCK_EN
                // A non-last beat opens or continues a packet; ptr stays put
                // until the packet closes.
                if (!last_sel) begin
                    lock_d  = 1'b1;
                    owner_d = idx;
                end else begin
                    lock_d  = 1'b0;
                    ptr_d   = ptr_after;
                end
`else
                ptr_d = ptr_after;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= 1'b0;
            owner_q     <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= lock_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign bus.in_ready  = load ? grant : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
